// File: rtl/subu_pkg.sv
// Shared definitions for the bit-serial unsigned subtractor.
package subu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } subu_state_e;

endpackage : subu_pkg

// File: rtl/fsub1.sv
// One-bit full subtractor: difference and borrow-out for a single bit slice.
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fsub1

// File: rtl/subu_serial.sv
// Bit-serial unsigned subtractor: one bit per cycle LSB-first, result and
// final borrow registered on completion with a one-cycle done pulse.
module subu_serial
  import subu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] rd,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  subu_state_e      r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;

  fsub1 u_fsub1 (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      rd      <= '0;
      borrow  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= rs;
            r_b     <= rt;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          // Once all bits are consumed the operands are zero-filled, so the
          // borrow out of the slice equals the final borrow.
          if (r_cnt == CW'(WIDTH)) begin
            rd      <= r_res;
            borrow  <= w_bout;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_bout;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : subu_serial
